top_buffer: RTL and testbench

//   Code-compression fetch subsystem: replays a dictionary-compressed program from ROM, expands tokens via a

---
 rtl/top_buffer.sv | 199 +++++++++++++++++++
 tb/tb_top_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/top_buffer.sv
`default_nettype none
// ============================================================================
// Module      : top_buffer
// Description : Code-compression fetch subsystem. Replays a dictionary-
//               compressed program from ROM, expands 4-bit tokens through a
//               token table, queues expanded instructions in a small FIFO and
//               presents one 32-bit instruction per cycle with its byte PC.
//
//               The ROM images are supplied as flat elaboration-time
//               parameters (word i at bits [i*WIDTH +: WIDTH]). This keeps the
//               block self-contained without any file access from the RTL.
//
// Ports       : clk             in  1      single clock, rising edge
//               reset           in  1      synchronous, active-high
//               PCcpu           out WIDTH  byte address of DecompressInstr
//               DecompressInstr out WIDTH  expanded instruction
//               InstrValid      out 1      outputs valid this cycle
//
// Revision    : 1.0  initial release
// ============================================================================
module top_buffer #(
    parameter int                          WIDTH       = 32,
    parameter logic [WIDTH-1:0]            PC_INC      = WIDTH'(4),
    parameter logic [3:0]                  ESC_TOKEN   = 4'b1111,
    parameter int                          BUF_DEPTH   = 4,
    parameter int                          TABLE_DEPTH = 32,
    parameter int                          PROG_DEPTH  = 77,
    // Token table image; TABLE_DEPTH must be at least 16 (4-bit index).
    parameter logic [TABLE_DEPTH*WIDTH-1:0] TOKEN_IMAGE = '0,
    // Compressed program image.
    parameter logic [PROG_DEPTH*WIDTH-1:0]  PROG_IMAGE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] PCcpu,
    output logic [WIDTH-1:0] DecompressInstr,
    output logic             InstrValid
);

    localparam int c_NIBBLES = WIDTH / 4;
    localparam int c_CNT_W   = $clog2(c_NIBBLES + 1);
    localparam int c_ADDR_W  = $clog2(PROG_DEPTH + 1);
    localparam int c_PTR_W   = $clog2(BUF_DEPTH);
    localparam int c_FCNT_W  = $clog2(BUF_DEPTH + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ADDR_W-1:0] r_addr_q, w_addr_d;   // next PROG word to read
    logic [WIDTH-1:0]    r_tok_q,  w_tok_d;    // token shift register
    logic [c_CNT_W-1:0]  r_cnt_q,  w_cnt_d;    // nibbles left (0 = empty)

    logic [WIDTH-1:0]    r_fifo_q [BUF_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr_q;
    logic [c_PTR_W-1:0]  r_rptr_q;
    logic [c_FCNT_W-1:0] r_fcnt_q;

    logic [WIDTH-1:0]    r_pc_next_q;          // PC given to the next pop
    logic [WIDTH-1:0]    r_pc_q;
    logic [WIDTH-1:0]    r_instr_q;
    logic                r_valid_q;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_prog_word;
    logic [WIDTH-1:0] w_tab_word;
    logic [3:0]       w_nibble;
    logic             w_has_word;
    logic             w_pop;
    logic             w_room;
    logic             w_decode;
    logic             w_is_esc;
    logic             w_push;
    logic [WIDTH-1:0] w_push_data;

    assign w_nibble   = r_tok_q[WIDTH-1 -: 4];
    assign w_has_word = (r_addr_q < c_ADDR_W'(PROG_DEPTH));
    assign w_pop      = (r_fcnt_q != '0);
    // A pop in the same cycle frees a slot before the push lands.
    assign w_room     = (r_fcnt_q != c_FCNT_W'(BUF_DEPTH)) || w_pop;
    assign w_decode   = (r_cnt_q != '0) && w_room;
    assign w_is_esc   = (w_nibble == ESC_TOKEN);

    // Program ROM read port (asynchronous, indexed by r_addr_q).
    always_comb begin
        w_prog_word = '0;
        for (int i = 0; i < PROG_DEPTH; i++) begin
            if (r_addr_q == c_ADDR_W'(i)) begin
                w_prog_word = PROG_IMAGE[i*WIDTH +: WIDTH];
            end
        end
    end

    // Token table read port; only the first 16 entries are reachable.
    always_comb begin
        w_tab_word = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_nibble == 4'(i)) begin
                w_tab_word = TOKEN_IMAGE[i*WIDTH +: WIDTH];
            end
        end
    end

    // Fetch / decode next-state.
    always_comb begin
        w_addr_d    = r_addr_q;
        w_tok_d     = r_tok_q;
        w_cnt_d     = r_cnt_q;
        w_push      = 1'b0;
        w_push_data = '0;

        if (w_decode) begin
            if (w_is_esc) begin
                // The word at r_addr_q is the raw instruction: push it
                // straight from the ROM port and drop the rest of the token
                // word. The following word is fetched next cycle.
                w_cnt_d = '0;
                if (w_has_word) begin
                    w_push      = 1'b1;
                    w_push_data = w_prog_word;
                    w_addr_d    = r_addr_q + c_ADDR_W'(1);
                end
            end else begin
                w_push      = 1'b1;
                w_push_data = w_tab_word;
                w_tok_d     = r_tok_q << 4;
                w_cnt_d     = r_cnt_q - c_CNT_W'(1);
            end
        end

        // Refill when empty, or while the last nibble is being consumed so
        // that the steady state sustains one instruction per cycle. An escape
        // owns the ROM port this cycle, so no refill then.
        if (w_has_word && !(w_decode && w_is_esc) &&
            ((r_cnt_q == '0) || ((r_cnt_q == c_CNT_W'(1)) && w_decode))) begin
            w_tok_d  = w_prog_word;
            w_cnt_d  = c_CNT_W'(c_NIBBLES);
            w_addr_d = r_addr_q + c_ADDR_W'(1);
        end
    end

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(BUF_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Control, FIFO pointers and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_q    <= '0;
            r_tok_q     <= '0;
            r_cnt_q     <= '0;
            r_wptr_q    <= '0;
            r_rptr_q    <= '0;
            r_fcnt_q    <= '0;
            r_pc_next_q <= '0;
            r_pc_q      <= '0;
            r_instr_q   <= '0;
            r_valid_q   <= 1'b0;
        end else begin
            r_addr_q <= w_addr_d;
            r_tok_q  <= w_tok_d;
            r_cnt_q  <= w_cnt_d;

            if (w_push) begin
                r_wptr_q <= ptr_inc(r_wptr_q);
            end

            if (w_pop) begin
                r_rptr_q    <= ptr_inc(r_rptr_q);
                r_instr_q   <= r_fifo_q[r_rptr_q];
                r_pc_q      <= r_pc_next_q;
                r_pc_next_q <= r_pc_next_q + PC_INC;
            end
            r_valid_q <= w_pop;

            case ({w_push, w_pop})
                2'b10:   r_fcnt_q <= r_fcnt_q + c_FCNT_W'(1);
                2'b01:   r_fcnt_q <= r_fcnt_q - c_FCNT_W'(1);
                default: r_fcnt_q <= r_fcnt_q;
            endcase
        end
    end

    // FIFO storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_q[r_wptr_q] <= w_push_data;
        end
    end

    assign PCcpu           = r_pc_q;
    assign DecompressInstr = r_instr_q;
    assign InstrValid      = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_top_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_buffer
// Description : Self-checking bench for top_buffer. A directed compressed
//               program exercises table tokens, escapes, escape-dense words
//               and end of program; expected instructions are queued and
//               compared by an independent output monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_top_buffer;

    localparam int W    = 32;
    localparam int PD   = 12;
    localparam int TD   = 32;
    localparam int NEXP = 29;

    // Program, word 11 first (MSB) down to word 0.
    localparam logic [PD*W-1:0] c_prog = {
        32'hA5A5A5A5,   // 11 raw
        32'h1234567F,   // 10 tokens 1..7 then escape
        32'h0BADF00D,   //  9 raw
        32'hF0000000,   //  8 escape
        32'h12345678,   //  7 raw
        32'hFFFFFFFF,   //  6 escape (rest discarded)
        32'hCAFEF00D,   //  5 raw
        32'h5F000000,   //  4 token 5 then escape
        32'hDEADBEEF,   //  3 raw
        32'hF0000000,   //  2 escape
        32'h89ABCDE0,   //  1 tokens
        32'h01234567    //  0 tokens
    };

    function automatic logic [TD*W-1:0] mk_table();
        logic [TD*W-1:0] t;
        t = '0;
        for (int i = 0; i < 15; i++) begin
            t[i*W +: W] = 32'(i) * 32'h11111111;
        end
        return t;
    endfunction

    localparam logic [TD*W-1:0] c_table = mk_table();

    localparam logic [31:0] c_exp [NEXP] = '{
        32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
        32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777,
        32'h88888888, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB,
        32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'h00000000,
        32'hDEADBEEF, 32'h55555555, 32'hCAFEF00D, 32'h12345678,
        32'h0BADF00D, 32'h11111111, 32'h22222222, 32'h33333333,
        32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777,
        32'hA5A5A5A5
    };

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] PCcpu;
    logic [31:0] DecompressInstr;
    logic        InstrValid;

    exp_t q[$];
    int   n_checks;
    int   n_fail;

    top_buffer #(
        .WIDTH       (W),
        .PC_INC      (32'd4),
        .ESC_TOKEN   (4'hF),
        .BUF_DEPTH   (4),
        .TABLE_DEPTH (TD),
        .PROG_DEPTH  (PD),
        .TOKEN_IMAGE (c_table),
        .PROG_IMAGE  (c_prog)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .PCcpu           (PCcpu),
        .DecompressInstr (DecompressInstr),
        .InstrValid      (InstrValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic load_golden();
        q.delete();
        for (int i = 0; i < NEXP; i++) begin
            q.push_back({c_exp[i], 32'(i * 4)});
        end
    endtask

    // Waits up to three cycles for the first valid output after reset release.
    task automatic wait_first_valid(input string name);
        int k;
        k = 0;
        while (InstrValid !== 1'b1 && k < 3) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'd0, InstrValid}, 32'd1);
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (InstrValid === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output actual instr=%h pc=%h required=none",
                         DecompressInstr, PCcpu);
            end else begin
                e = q.pop_front();
                chk("instr", DecompressInstr, e.instr);
                chk("pc", PCcpu, e.pc);
            end
        end
    end

    initial begin
        int k;
        int extra;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        q.delete();

        // Reset held for two cycles.
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", {31'd0, InstrValid}, 32'd0);
            chk("rst_pc", PCcpu, 32'd0);
            chk("rst_instr", DecompressInstr, 32'd0);
        end
        load_golden();
        reset = 1'b0;
        wait_first_valid("start_latency");

        // Run until PC 0x40 is presented, then pulse reset for one cycle.
        k = 0;
        while (!(InstrValid === 1'b1 && PCcpu == 32'h40) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL reach_pc40 actual=timeout required=pc_00000040");
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        load_golden();
        @(negedge clk);
        chk("midrst_valid", {31'd0, InstrValid}, 32'd0);
        chk("midrst_pc", PCcpu, 32'd0);
        reset = 1'b0;
        wait_first_valid("restart_latency");

        // Full run to the end of the program.
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain_remaining", 32'(q.size()), 32'd0);

        // After the end, outputs stay idle and hold the final instruction/PC.
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (InstrValid !== 1'b0) extra++;
        end
        chk("end_idle_valids", 32'(extra), 32'd0);
        chk("end_instr", DecompressInstr, 32'hA5A5A5A5);
        chk("end_pc", PCcpu, 32'h00000070);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
